regfile_arbiter: RTL and testbench
==================================

# regfile_arbiter

Two-requester arbiter and sequencer for the team's 8-entry x 8-bit 1RW flip-flop register file. The register file storage and its per-entry written mask are instantiated inside this block. Each cycle, at most one of two clients (port 0, port 1) is granted a single read or write through a valid/ready handshake, and the result comes back as a one-cycle response pulse. Reads of entries never written since reset are flagged as errors.

## Interface
Parameters:
- DATA_W, 8, word width
- DEPTH, 8, entry count; must be a power of two
- ADDR_W, $clog2(DEPTH), address width

Ports (i = 0, 1; one identical set per requester):
- clk  in  1  rising-edge clock; the block has one clock
- resetn  in  1  asynchronous, active-low reset
- req_valid_i  in  1  request present; held stable until accepted
- req_ready_i  out  1  request granted this cycle
- req_wr_i  in  1  1 = write, 0 = read
- req_addr_i  in  ADDR_W  entry index
- req_wdata_i  in  DATA_W  write data
- rsp_valid_i  out  1  one-cycle response pulse
- rsp_rdata_i  out  DATA_W  read data; 0 on writes and on errors
- rsp_error_i  out  1  1 = read of an unwritten entry
- busy  out  1  a request was accepted in the previous cycle (that response is visible this cycle)

## Operation
- Accept condition: req_valid_i && req_ready_i. At most one port is accepted per cycle.
- The ready signals are combinational from the valid signals and the priority pointer. A port with valid low never sees ready high.
- Arbitration (default):
  - If only one port is valid, that port gets ready.
  - If both ports are valid, the port named by rr_ptr wins.
  - After every accept, rr_ptr moves to the other port.
  - rr_ptr is not updated in idle cycles.
- Accepted write: mem[addr] <= wdata and written[addr] <= 1. The response carries rdata = 0 and error = 0.
- Accepted read:
  - If written[addr] = 1, the response carries rdata = mem[addr] and error = 0.
  - Otherwise the response carries rdata = 0 and error = 1. The read has no side effect on the mask.
- Responses go only to the port that was accepted. The other port's rsp_valid stays 0.
- Same-address conflicts: the requests are serialized in accept order. A read accepted the cycle after a write to the same entry returns the newly written data.
- There is no response backpressure. The requester must be able to take the response in the cycle it appears.

## Timing
- Response latency is exactly 1 cycle: a request accepted at edge N produces rsp_valid, rdata and error during cycle N+1.
- rsp_valid is high for exactly one cycle per accept.
- Throughput is 1 accept per cycle in aggregate. Each port gets at least 1 accept every 2 cycles while it holds valid, so the worst-case wait is 1 cycle.
- Reset values:
  - req_ready follows the combinational rule (0 while all valids are 0).
  - rsp_valid_i = 0, rsp_rdata_i = 0, rsp_error_i = 0, busy = 0.
  - rr_ptr = port 0.
  - written mask = all 0.
  - mem contents are not reset.
- Reset asserted mid-operation: a pending response is dropped and never delivered, and the whole mask clears. After reset releases, every read errors until the entry is rewritten.
- Response outputs hold 0 whenever rsp_valid_i = 0.

## Configuration
- REGFILE_ARB_FIXED_PRIO_EN
  - Defined: port 0 always wins when both ports are valid, and rr_ptr is removed. Port 1 can starve; this is by design.
  - Undefined (default): round-robin as described under Operation.
  - All other behaviour is identical in both builds.

## Test plan
- After reset, port 0 reads address 3 → cycle N+1: rsp_valid_0 = 1, rsp_error_0 = 1, rsp_rdata_0 = 0x00.
- Port 0 writes 0xA5 to address 5, then reads address 5 → the write response has error 0; the read returns 0xA5 with error 0.
- Both ports are valid every cycle for 6 cycles (port 0 writes address 2, port 1 reads address 2):
  - Default build: grants alternate 0,1,0,1,0,1.
  - Port 1's first read returns the data port 0 wrote.
  - REGFILE_ARB_FIXED_PRIO_EN build: port 0 gets all 6 grants.
- Write 0x3C to address 7, assert resetn low for 1 cycle mid-stream while a read is pending → no rsp_valid is delivered; a read of address 7 after reset returns error 1 and rdata 0.
- Write all 8 addresses with value addr*0x11, then read 0..7 back-to-back from port 1 → 8 consecutive response pulses, each with rdata = addr*0x11 and error 0.
- While port 1's valid is held low, port 0 issues 4 requests → port 0 is ready every cycle; rsp_valid_1 stays 0 throughout.

Source files
------------

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: arbitrates two requesters onto an 8 x 8 flip-flop register
// file. The storage and the per-entry written mask live inside this block.
// Each cycle at most one request is accepted through a valid/ready handshake.
// The accepted port then gets a one-cycle response pulse in the following
// cycle. Reading an entry that has not been written since reset returns
// error = 1 with rdata = 0.
//
// Optional build macro: REGFILE_ARB_FIXED_PRIO_EN
//   defined   -> port 0 always wins a tie and there is no rr pointer
//   undefined -> round-robin; the pointer toggles after every accept
//
// Ports (x = 0, 1):
//   clk, resetn         clock and asynchronous active-low reset
//   req_valid_x         request present, held stable until it is accepted
//   req_ready_x         request is granted this cycle (combinational)
//   req_wr_x            1 = write, 0 = read
//   req_addr_x          entry index
//   req_wdata_x         write data
//   rsp_valid_x         one-cycle response pulse
//   rsp_rdata_x         read data; 0 on writes, on errors and when idle
//   rsp_error_x         read of an entry that was never written
//   busy                a request was accepted in the previous cycle
module regfile_arbiter #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid_0,
    output logic              req_ready_0,
    input  logic              req_wr_0,
    input  logic [ADDR_W-1:0] req_addr_0,
    input  logic [DATA_W-1:0] req_wdata_0,
    output logic              rsp_valid_0,
    output logic [DATA_W-1:0] rsp_rdata_0,
    output logic              rsp_error_0,
    input  logic              req_valid_1,
    output logic              req_ready_1,
    input  logic              req_wr_1,
    input  logic [ADDR_W-1:0] req_addr_1,
    input  logic [DATA_W-1:0] req_wdata_1,
    output logic              rsp_valid_1,
    output logic [DATA_W-1:0] rsp_rdata_1,
    output logic              rsp_error_1,
    output logic              busy
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  written_q, written_d;

    logic              rsp_valid_0_q, rsp_valid_0_d;
    logic              rsp_valid_1_q, rsp_valid_1_d;
    logic [DATA_W-1:0] rsp_rdata_0_q, rsp_rdata_0_d;
    logic [DATA_W-1:0] rsp_rdata_1_q, rsp_rdata_1_d;
    logic              rsp_error_0_q, rsp_error_0_d;
    logic              rsp_error_1_q, rsp_error_1_d;
    logic              busy_q, busy_d;

    logic              grant_0, grant_1, any_acc;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [DATA_W-1:0] rd_data;
    logic              rd_err;

`ifdef REGFILE_ARB_FIXED_PRIO_EN
    assign grant_0 = req_valid_0;
    assign grant_1 = req_valid_1 && !req_valid_0;
`else
    // rr_ptr_q names the port that wins when both ports are valid.
    logic rr_ptr_q, rr_ptr_d;

    assign grant_0 = req_valid_0 && (!req_valid_1 || !rr_ptr_q);
    assign grant_1 = req_valid_1 && (!req_valid_0 ||  rr_ptr_q);

    // After an accept the pointer moves to the port that was not served.
    // Idle cycles leave it unchanged.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (any_acc) begin
            rr_ptr_d = grant_0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    assign req_ready_0 = grant_0;
    assign req_ready_1 = grant_1;
    assign any_acc     = grant_0 || grant_1;

    assign sel_wr    = grant_1 ? req_wr_1    : req_wr_0;
    assign sel_addr  = grant_1 ? req_addr_1  : req_addr_0;
    assign sel_wdata = grant_1 ? req_wdata_1 : req_wdata_0;

    always_comb begin
        written_d     = written_q;
        rd_data       = '0;
        rd_err        = 1'b0;
        rsp_valid_0_d = grant_0;
        rsp_valid_1_d = grant_1;
        rsp_rdata_0_d = '0;
        rsp_rdata_1_d = '0;
        rsp_error_0_d = 1'b0;
        rsp_error_1_d = 1'b0;
        busy_d        = any_acc;
        if (any_acc) begin
            if (sel_wr) begin
                written_d[sel_addr] = 1'b1;
            end else if (written_q[sel_addr]) begin
                rd_data = mem_q[sel_addr];
            end else begin
                rd_err = 1'b1;
            end
        end
        if (grant_0) begin
            rsp_rdata_0_d = rd_data;
            rsp_error_0_d = rd_err;
        end
        if (grant_1) begin
            rsp_rdata_1_d = rd_data;
            rsp_error_1_d = rd_err;
        end
    end

    // Storage is not reset; the written mask is what guards reads after reset.
    always_ff @(posedge clk) begin
        if (any_acc && sel_wr) begin
            mem_q[sel_addr] <= sel_wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            written_q     <= '0;
            rsp_valid_0_q <= 1'b0;
            rsp_valid_1_q <= 1'b0;
            rsp_rdata_0_q <= '0;
            rsp_rdata_1_q <= '0;
            rsp_error_0_q <= 1'b0;
            rsp_error_1_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            written_q     <= written_d;
            rsp_valid_0_q <= rsp_valid_0_d;
            rsp_valid_1_q <= rsp_valid_1_d;
            rsp_rdata_0_q <= rsp_rdata_0_d;
            rsp_rdata_1_q <= rsp_rdata_1_d;
            rsp_error_0_q <= rsp_error_0_d;
            rsp_error_1_q <= rsp_error_1_d;
            busy_q        <= busy_d;
        end
    end

    assign rsp_valid_0 = rsp_valid_0_q;
    assign rsp_valid_1 = rsp_valid_1_q;
    assign rsp_rdata_0 = rsp_rdata_0_q;
    assign rsp_rdata_1 = rsp_rdata_1_q;
    assign rsp_error_0 = rsp_error_0_q;
    assign rsp_error_1 = rsp_error_1_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter. Each table row holds the request inputs for both
// ports and the expected ready pair for that cycle. A reference model of the
// memory and the written mask computes the response that each accept should
// produce. That response is queued and compared one cycle later, and the
// bench also checks a queued idle record on cycles with no accept. The
// reset-during-pending-read case is a separate hand-written sequence.
module tb_regfile_arbiter;

    logic       clk = 1'b0;
    logic       resetn;
    logic       req_valid_0, req_ready_0, req_wr_0;
    logic [2:0] req_addr_0;
    logic [7:0] req_wdata_0;
    logic       rsp_valid_0, rsp_error_0;
    logic [7:0] rsp_rdata_0;
    logic       req_valid_1, req_ready_1, req_wr_1;
    logic [2:0] req_addr_1;
    logic [7:0] req_wdata_1;
    logic       rsp_valid_1, rsp_error_1;
    logic [7:0] rsp_rdata_1;
    logic       busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_arbiter dut (
        .clk(clk), .resetn(resetn),
        .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_wr_0(req_wr_0),
        .req_addr_0(req_addr_0), .req_wdata_0(req_wdata_0),
        .rsp_valid_0(rsp_valid_0), .rsp_rdata_0(rsp_rdata_0), .rsp_error_0(rsp_error_0),
        .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_wr_1(req_wr_1),
        .req_addr_1(req_addr_1), .req_wdata_1(req_wdata_1),
        .rsp_valid_1(rsp_valid_1), .rsp_rdata_1(rsp_rdata_1), .rsp_error_1(rsp_error_1),
        .busy(busy)
    );

    typedef struct {
        logic       v0, wr0;
        logic [2:0] a0;
        logic [7:0] d0;
        logic       v1, wr1;
        logic [2:0] a1;
        logic [7:0] d1;
        logic       r0, r1;
    } vec_t;

    typedef struct {
        logic       v0, v1;
        logic [7:0] rdata;
        logic       err;
    } rsp_t;

    vec_t tbl[$];
    rsp_t sb_q[$];
    logic [7:0] mem_m [8];
    logic [7:0] wr_m;

    function automatic vec_t mk(input logic v0, input logic wr0, input logic [2:0] a0,
                                input logic [7:0] d0, input logic v1, input logic wr1,
                                input logic [2:0] a1, input logic [7:0] d1,
                                input logic r0, input logic r1);
        vec_t v;
        v.v0 = v0; v.wr0 = wr0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.wr1 = wr1; v.a1 = a1; v.d1 = d1;
        v.r0 = r0; v.r1 = r1;
        return v;
    endfunction

    function automatic rsp_t idle_rsp();
        rsp_t e;
        e.v0 = 1'b0; e.v1 = 1'b0; e.rdata = 8'h00; e.err = 1'b0;
        return e;
    endfunction

    // Reference model of one accepted request.
    task automatic model_apply(input logic wr, input logic [2:0] a, input logic [7:0] d,
                               output logic [7:0] rdata, output logic err);
        if (wr) begin
            mem_m[a] = d;
            wr_m[a]  = 1'b1;
            rdata    = 8'h00;
            err      = 1'b0;
        end else if (wr_m[a]) begin
            rdata = mem_m[a];
            err   = 1'b0;
        end else begin
            rdata = 8'h00;
            err   = 1'b1;
        end
    endtask

    task automatic check_rsp(input string name);
        rsp_t e;
        logic [20:0] got, exp;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e   = sb_q.pop_front();
        got = {rsp_valid_0, rsp_valid_1, rsp_rdata_0, rsp_error_0, rsp_rdata_1, rsp_error_1, busy};
        exp = {e.v0, e.v1, (e.v0 ? e.rdata : 8'h00), (e.v0 ? e.err : 1'b0),
               (e.v1 ? e.rdata : 8'h00), (e.v1 ? e.err : 1'b0), (e.v0 | e.v1)};
        if (got !== exp) begin
            errors++;
            $display("FAIL rsp %s: got v0=%b v1=%b rd0=%h e0=%b rd1=%h e1=%b busy=%b, exp v0=%b v1=%b rd0=%h e0=%b rd1=%h e1=%b busy=%b",
                     name, got[20], got[19], got[18:11], got[10], got[9:2], got[1], got[0],
                     exp[20], exp[19], exp[18:11], exp[10], exp[9:2], exp[1], exp[0]);
        end
    endtask

    task automatic drive(input vec_t v);
        req_valid_0 = v.v0; req_wr_0 = v.wr0; req_addr_0 = v.a0; req_wdata_0 = v.d0;
        req_valid_1 = v.v1; req_wr_1 = v.wr1; req_addr_1 = v.a1; req_wdata_1 = v.d1;
    endtask

    // One cycle: check last cycle's response, drive this cycle's requests,
    // check ready, and queue the response the model expects next cycle.
    task automatic step(input vec_t v, input string name);
        rsp_t e;
        logic [7:0] rd;
        logic er;
        @(negedge clk);
        check_rsp(name);
        drive(v);
        #1;
        checks++;
        if ({req_ready_0, req_ready_1} !== {v.r0, v.r1}) begin
            errors++;
            $display("FAIL ready %s: got %b%b exp %b%b", name, req_ready_0, req_ready_1, v.r0, v.r1);
        end
        e = idle_rsp();
        if (v.v0 && v.r0) begin
            model_apply(v.wr0, v.a0, v.d0, rd, er);
            e.v0 = 1'b1; e.rdata = rd; e.err = er;
        end else if (v.v1 && v.r1) begin
            model_apply(v.wr1, v.a1, v.d1, rd, er);
            e.v1 = 1'b1; e.rdata = rd; e.err = er;
        end
        sb_q.push_back(e);
    endtask

    initial begin
        vec_t idle;
        logic r0;
        idle = mk(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
        wr_m = 8'h00;
        for (int i = 0; i < 8; i++) mem_m[i] = 8'h00;
        drive(idle);
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, rsp_rdata_0, rsp_rdata_1,
             rsp_error_0, rsp_error_1, busy} !== 25'h0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b%b v=%b%b rd=%h/%h e=%b%b busy=%b exp all zero",
                     req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, rsp_rdata_0, rsp_rdata_1,
                     rsp_error_0, rsp_error_1, busy);
        end
        resetn = 1'b1;
        sb_q.push_back(idle_rsp());

        // Contention right after reset: port 0 writes addr 2, port 1 reads it.
        for (int k = 0; k < 6; k++) begin
`ifdef REGFILE_ARB_FIXED_PRIO_EN
            r0 = 1'b1;
`else
            r0 = (k % 2 == 0);
`endif
            tbl.push_back(mk(1, 1, 2, 8'h20 + 8'(k), 1, 0, 2, 8'h00, r0, !r0));
        end
        // Read of a never-written entry.
        tbl.push_back(mk(1, 0, 3, 8'h00, 0, 0, 0, 8'h00, 1, 0));
        // Write then read back.
        tbl.push_back(mk(1, 1, 5, 8'hA5, 0, 0, 0, 8'h00, 1, 0));
        tbl.push_back(mk(1, 0, 5, 8'h00, 0, 0, 0, 8'h00, 1, 0));
        // Fill all entries from port 0, then read them back-to-back from port 1.
        for (int a = 0; a < 8; a++)
            tbl.push_back(mk(1, 1, 3'(a), 8'(a * 8'h11), 0, 0, 0, 8'h00, 1, 0));
        for (int a = 0; a < 8; a++)
            tbl.push_back(mk(0, 0, 0, 8'h00, 1, 0, 3'(a), 8'h00, 0, 1));
        // Port 1 idle while port 0 streams 4 requests.
        tbl.push_back(mk(1, 1, 1, 8'h77, 0, 0, 0, 8'h00, 1, 0));
        tbl.push_back(mk(1, 0, 1, 8'h00, 0, 0, 0, 8'h00, 1, 0));
        tbl.push_back(mk(1, 0, 6, 8'h00, 0, 0, 0, 8'h00, 1, 0));
        tbl.push_back(mk(1, 1, 0, 8'h01, 0, 0, 0, 8'h00, 1, 0));
        // Write addr 7 ahead of the reset sequence.
        tbl.push_back(mk(1, 1, 7, 8'h3C, 0, 0, 0, 8'h00, 1, 0));

        foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

        // Reset while a read of addr 7 is pending: its response must vanish.
        @(negedge clk);
        check_rsp("pre_reset");
        drive(mk(1, 0, 7, 8'h00, 0, 0, 0, 8'h00, 1, 0));
        @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        checks++;
        if ({rsp_valid_0, rsp_valid_1, busy, rsp_rdata_0, rsp_error_0} !== 12'h000) begin
            errors++;
            $display("FAIL dropped_rsp: got v=%b%b busy=%b rd0=%h e0=%b exp all zero",
                     rsp_valid_0, rsp_valid_1, busy, rsp_rdata_0, rsp_error_0);
        end
        drive(idle);
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        wr_m = 8'h00;
        sb_q.delete();
        sb_q.push_back(idle_rsp());
        step(mk(1, 0, 7, 8'h00, 0, 0, 0, 8'h00, 1, 0), "read7_after_reset");
        step(idle, "drain0");
        step(idle, "drain1");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
